imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-fetch path. Receives a byte stream over valid/ready and packs it
//  little-endian into 32-bit instructions. Writes each word into instruction memory at PC 0,1,2,...
//  Holds the core in reset while loading, then releases it. Sits between the program source
//  (host/UART bridge) and the cpu's instruction memory, and drives the cpu's rst input.
// PARAMETERS
//  XLEN        32  instruction/data word width (bits); must be 32
//  PC_BITS     5   word-address width of instruction memory; depth = 2**PC_BITS words
//  HOLD_CYCLES 3   cycles cpu_rst stays high after final write before release (>=1)
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous, active-high reset
//  s_valid      in   1          byte valid
//  s_data       in   8          byte payload
//  s_last       in   1          qualifies last byte of program (sampled with s_valid&&s_ready)
//  s_ready      out  1          loader accepts a byte this cycle
//  reload       in   1          pulse: restart load from PC 0 (honoured in RUN only)
//  imem_we      out  1          instruction memory write strobe (single cycle)
//  imem_addr    out  PC_BITS    word address for write
//  imem_wdata   out  XLEN       instruction word for write
//  cpu_rst      out  1          reset to cpu core; high while not RUN
//  load_done    out  1          high in RUN
//  word_count   out  PC_BITS+1  words written in current load (saturates at 2**PC_BITS)
//  err_overflow out  1          sticky: bytes arrived with memory already full; cleared by rst/reload
// BEHAVIOUR
//  Reset values: state=LOAD, s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1,
//   load_done=0, word_count=0, err_overflow=0, byte index=0, pack buffer=0. Memory contents untouched.
//  FSM: LOAD -> FLUSH -> HOLD -> RUN; RUN -reload-> LOAD. rst from any state -> LOAD, no write issued.
//  LOAD: s_ready=1. Handshake = s_valid&&s_ready. Byte k (0..3) goes to buffer bits [8k+7:8k].
//   On 4th byte: next cycle imem_we=1, imem_wdata=packed word, imem_addr=word_count[PC_BITS-1:0];
//   word_count increments the same edge. Back-to-back words write on consecutive 4-byte boundaries.
//   Write latency = 1 cycle after the accepting edge. imem_we is high for exactly 1 cycle per word.
//  s_last on a handshake -> FLUSH next cycle; s_ready=0 from then until next LOAD.
//   If byte index !=0 after s_last byte, the partial word is zero-padded (unused bytes = 0x00, the NOP
//   encoding) and written in FLUSH. If s_last hits the 4th byte, that normal write occurs in FLUSH.
//  Full: word_count==2**PC_BITS. Further bytes are still accepted (s_ready=1) but dropped.
//   No imem_we. err_overflow<=1. s_last is still honoured. No address wrap-around.
//  FLUSH: 1 cycle -> HOLD. HOLD: down-counter HOLD_CYCLES, then RUN; cpu_rst=1 throughout.
//  RUN: cpu_rst=0, load_done=1, s_ready=0. reload -> LOAD next edge: cpu_rst=1 same edge,
//   word_count/byte index/err_overflow cleared. reload outside RUN is ignored.
//  Simultaneous rst and reload: rst wins. Empty program (s_last on first byte) -> 1 padded word.
// STRUCTURE
//  cpu_pkg: XLEN, PC_BITS defaults, NOP_INST=32'h00000000, loader state encodings.
//  Sub-module imem_byte_packer (byte index, pack buffer, zero-pad on last). FSM, address and
//   hold counter stay in imem_loader.
// TESTING
//  1 bytes 13 00 50 00 | 93 00 A0 00(last) -> we@addr0=0x00500013, we@addr1=0x00A00093;
//    cpu_rst falls exactly HOLD_CYCLES+1 cycles after the 2nd write; load_done=1.
//  2 bytes AA BB CC DD EE FF(last) -> addr0=0xDDCCBBAA, addr1=0x0000FFEE; word_count=2.
//  3 PC_BITS=2, 20 bytes then last -> 4 writes addr0..3, no 5th write, err_overflow=1, RUN reached.
//  4 random s_valid gaps (1-5 idle cycles) over 3 words -> identical writes to gap-free run.
//  5 reload in RUN -> cpu_rst=1 next cycle, word_count=0; new 4-byte load writes addr0.
//  6 rst after 2 bytes of word 0 -> no imem_we; next 4 bytes 01 02 03 04 write addr0=0x04030201.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int PC_BITS_DEF = 5;

  // All-zero word doubles as the NOP used to pad a short final instruction.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into a word; emits a completed or zero-padded word on the
// accepting cycle.
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            accept,
  input  logic [7:0]      byte_in,
  input  logic            last,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  localparam int LANES = XLEN / 8;
  localparam int IW    = $clog2(LANES);

  logic [IW-1:0]   byte_idx_q, byte_idx_d;
  logic [XLEN-1:0] pack_q, pack_d;

  // Lanes above the current index are still zero, so an early 'last' yields NOP padding for free.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign word[8*gi +: 8] = (accept && (byte_idx_q == IW'(gi))) ? byte_in : pack_q[8*gi +: 8];
    end
  endgenerate

  assign word_valid = accept && (last || (byte_idx_q == IW'(LANES - 1)));

  always_comb begin
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    if (clr) begin
      byte_idx_d = '0;
      pack_d     = NOP_INST[XLEN-1:0];
    end else if (accept) begin
      if (word_valid) begin
        byte_idx_d = '0;
        pack_d     = NOP_INST[XLEN-1:0];
      end else begin
        byte_idx_d = byte_idx_q + IW'(1);
        pack_d     = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      pack_q     <= NOP_INST[XLEN-1:0];
    end else begin
      byte_idx_q <= byte_idx_d;
      pack_q     <= pack_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into instruction memory, holding the cpu in reset until the
// final word is written plus a short settle period.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int PC_BITS     = PC_BITS_DEF,
  parameter int HOLD_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [PC_BITS-1:0] imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               cpu_rst,
  output logic               load_done,
  output logic [PC_BITS:0]   word_count,
  output logic               err_overflow
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [PC_BITS:0] DEPTH = {1'b1, {PC_BITS{1'b0}}};

  loader_state_e      state_q, state_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               imem_we_q, imem_we_d;
  logic [PC_BITS-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;
  logic [PC_BITS:0]   word_count_q, word_count_d;
  logic               err_overflow_q, err_overflow_d;

  logic            handshake, mem_full, pk_accept, pk_clr, pk_valid;
  logic [XLEN-1:0] pk_word;

  assign handshake = s_valid && (state_q == ST_LOAD);
  assign mem_full  = (word_count_q == DEPTH);
  // Once memory is full, bytes are swallowed without reaching the packer so nothing wraps.
  assign pk_accept = handshake && !mem_full;

  imem_byte_packer #(.XLEN(XLEN)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .accept     (pk_accept),
    .byte_in    (s_data),
    .last       (s_last),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    word_count_d   = word_count_q;
    err_overflow_d = err_overflow_q;
    pk_clr         = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (handshake) begin
          if (mem_full) err_overflow_d = 1'b1;
          if (s_last)   state_d        = ST_FLUSH;
        end
        if (pk_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_count_q[PC_BITS-1:0];
          imem_wdata_d = pk_word;
          word_count_d = word_count_q + {{PC_BITS{1'b0}}, 1'b1};
        end
      end
      ST_FLUSH: begin
        state_d    = ST_HOLD;
        hold_cnt_d = HW'(HOLD_CYCLES - 1);
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d    = ST_RUN;
        else                  hold_cnt_d = hold_cnt_q - HW'(1);
      end
      ST_RUN: begin
        if (reload) begin
          state_d        = ST_LOAD;
          word_count_d   = '0;
          err_overflow_d = 1'b0;
          pk_clr         = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      hold_cnt_q     <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      word_count_q   <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      word_count_q   <= word_count_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign s_ready      = (state_q == ST_LOAD);
  assign cpu_rst      = (state_q != ST_RUN);
  assign load_done    = (state_q == ST_RUN);
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign word_count   = word_count_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized program loads checked against a chunk-and-pad reference model.
module tb_imem_loader;

  localparam int XLEN    = 32;
  localparam int PC_BITS = 2;
  localparam int HOLD    = 3;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic [7:0]         s_data = 8'h00;
  logic               s_last = 1'b0;
  logic               reload = 1'b0;
  logic               s_ready;
  logic               imem_we;
  logic [PC_BITS-1:0] imem_addr;
  logic [XLEN-1:0]    imem_wdata;
  logic               cpu_rst;
  logic               load_done;
  logic [PC_BITS:0]   word_count;
  logic               err_overflow;

  imem_loader #(.XLEN(XLEN), .PC_BITS(PC_BITS), .HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          run_cyc = -1;
  logic        cpu_rst_prev = 1'b1;
  logic [7:0]  prog_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // Observe writes and the cpu_rst release on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
      last_wr_cyc = cyc;
    end
    if (cpu_rst_prev === 1'b1 && cpu_rst === 1'b0) run_cyc = cyc;
    cpu_rst_prev = cpu_rst;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: program bytes chunked into groups of four, little-endian, zero-padded.
  function automatic logic [31:0] model_word(input int i);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4; j++)
      if (4*i + j < prog_q.size()) w[8*j +: 8] = prog_q[4*i + j];
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    check("reload_word_count", 64'(word_count), 64'd0);
    check("reload_err", 64'(err_overflow), 64'd0);
    check("reload_s_ready", 64'(s_ready), 64'd1);
  endtask

  // Streams prog_q with idle gaps; an optional reload pulse mid-load must be ignored.
  task automatic run_load(input string name, input int min_gap, input int max_gap, input int reload_at);
    int n, t, nw, ew;
    n = prog_q.size();
    wr_addr_q.delete();
    wr_data_q.delete();
    run_cyc = -1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, min_gap)) @(negedge clk);
      if (i == reload_at) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
      send_byte(prog_q[i], i == n - 1);
    end
    t = 0;
    while (load_done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({name, "_load_done"}, 64'(load_done), 64'd1);
    nw = (n + 3) / 4;
    ew = (nw > DEPTH) ? DEPTH : nw;
    check({name, "_write_count"}, 64'(wr_addr_q.size()), 64'(ew));
    for (int i = 0; i < ew && i < wr_addr_q.size(); i++) begin
      check({name, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
      check({name, "_data"}, 64'(wr_data_q[i]), 64'(model_word(i)));
    end
    check({name, "_word_count"}, 64'(word_count), 64'(ew));
    check({name, "_err_overflow"}, 64'(err_overflow), 64'(n > 4*DEPTH));
    check({name, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
    check({name, "_s_ready"}, 64'(s_ready), 64'd0);
    if (n <= 4*DEPTH)
      check({name, "_hold_timing"}, 64'(run_cyc - last_wr_cyc), 64'(HOLD + 1));
    $display("load %s: bytes=%0d writes=%0d word_count=%0d err_overflow=%0b",
             name, n, wr_addr_q.size(), word_count, err_overflow);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_err", 64'(err_overflow), 64'd0);

    prog_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    run_load("t1", 0, 0, -1);
    check("t1_word0", 64'(model_word(0)), 64'h0050_0013);

    do_reload();
    prog_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load("t2", 0, 0, -1);
    if (wr_data_q.size() == 2) check("t2_padded", 64'(wr_data_q[1]), 64'h0000_FFEE);

    do_reload();
    prog_q.delete();
    for (int i = 0; i < 21; i++) prog_q.push_back(8'($urandom));
    run_load("t3_overflow", 0, 0, -1);

    do_reload();
    prog_q.delete();
    for (int i = 0; i < 12; i++) prog_q.push_back(8'($urandom));
    run_load("t4_gaps", 1, 5, -1);

    do_reload();
    prog_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load("t5_reload", 0, 2, 2);

    do_reload();
    wr_addr_q.delete();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1;
    reload = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reload = 1'b0;
    @(negedge clk);
    check("t6_no_write", 64'(wr_addr_q.size()), 64'd0);
    check("t6_word_count", 64'(word_count), 64'd0);
    check("t6_s_ready", 64'(s_ready), 64'd1);
    prog_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load("t6_after_rst", 0, 0, -1);
    if (wr_data_q.size() == 1) check("t6_word", 64'(wr_data_q[0]), 64'h0403_0201);

    do_reload();
    prog_q = '{8'h7E};
    run_load("t7_single", 0, 0, -1);

    for (int r = 0; r < 6; r++) begin
      do_reload();
      prog_q.delete();
      for (int i = 0; i < int'($urandom_range(22, 1)); i++) prog_q.push_back(8'($urandom));
      run_load($sformatf("rand%0d", r), 0, 3, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
